// File: rtl/pwm_pkg.sv
// rtl/pwm_pkg.sv - shared PWM widths and fade FSM encoding
package pwm_pkg;

    localparam int PWM_DUTY_W = 16;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RAMP = 1'b1
    } fade_state_t;

endpackage

// File: rtl/fade_tick.sv
// rtl/fade_tick.sv - reloadable step-interval down-counter for the fade controller
module fade_tick
    import pwm_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic                  load,
    input  logic [PWM_DUTY_W-1:0] load_val,
    output logic                  tick
);

    logic [PWM_DUTY_W-1:0] r_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= load_val;
        end else if (en && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign tick = en && (r_count == '0);

endmodule

// File: rtl/pwm_fade_ctrl.sv
// rtl/pwm_fade_ctrl.sv - linear duty-cycle fade sequencer feeding pwm16
module pwm_fade_ctrl
    import pwm_pkg::*;
#(
    parameter logic [PWM_DUTY_W-1:0] DUTY_RESET = 16'h0000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cmd_valid,
    input  logic [PWM_DUTY_W-1:0] cmd_target,
    input  logic [PWM_DUTY_W-1:0] cmd_step,
    input  logic [PWM_DUTY_W-1:0] cmd_interval,
    output logic [PWM_DUTY_W-1:0] duty_cycle,
    output logic                  busy,
    output logic                  done
);

    fade_state_t           r_state;
    logic [PWM_DUTY_W-1:0] r_duty;
    logic [PWM_DUTY_W-1:0] r_target;
    logic [PWM_DUTY_W-1:0] r_step;
    logic [PWM_DUTY_W-1:0] r_interval;
    logic                  r_busy;
    logic                  r_done;

    fade_state_t           w_state_nxt;
    logic [PWM_DUTY_W-1:0] w_duty_nxt;
    logic [PWM_DUTY_W-1:0] w_target_nxt;
    logic [PWM_DUTY_W-1:0] w_step_nxt;
    logic [PWM_DUTY_W-1:0] w_interval_nxt;
    logic                  w_busy_nxt;
    logic                  w_done_nxt;

    logic                  w_tick;
    logic                  w_tick_load;
    logic [PWM_DUTY_W-1:0] w_tick_load_val;
    logic [PWM_DUTY_W:0]   w_sum;
    logic [PWM_DUTY_W:0]   w_diff;
    logic [PWM_DUTY_W-1:0] w_step_duty;

    // A new command always restarts the prescaler; otherwise each tick reloads the interval.
    assign w_tick_load     = cmd_valid || w_tick;
    assign w_tick_load_val = cmd_valid ? cmd_interval : r_interval;

    fade_tick u_fade_tick (
        .clk      (clk),
        .reset    (reset),
        .en       (r_state == ST_RAMP),
        .load     (w_tick_load),
        .load_val (w_tick_load_val),
        .tick     (w_tick)
    );

    // Carry/borrow bit keeps the saturating clamp honest at both ends of the range.
    assign w_sum  = {1'b0, r_duty} + {1'b0, r_step};
    assign w_diff = {1'b0, r_duty} - {1'b0, r_step};

    always_comb begin
        w_step_duty = r_target;
        if (r_target > r_duty) begin
            if (w_sum <= {1'b0, r_target}) begin
                w_step_duty = w_sum[PWM_DUTY_W-1:0];
            end
        end else begin
            if (!w_diff[PWM_DUTY_W] && (w_diff[PWM_DUTY_W-1:0] >= r_target)) begin
                w_step_duty = w_diff[PWM_DUTY_W-1:0];
            end
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_duty_nxt     = r_duty;
        w_target_nxt   = r_target;
        w_step_nxt     = r_step;
        w_interval_nxt = r_interval;
        w_busy_nxt     = r_busy;
        w_done_nxt     = 1'b0;

        if (cmd_valid) begin
            w_target_nxt   = cmd_target;
            w_step_nxt     = (cmd_step == '0) ? {{(PWM_DUTY_W-1){1'b0}}, 1'b1} : cmd_step;
            w_interval_nxt = cmd_interval;
            if (cmd_target == r_duty) begin
                w_state_nxt = ST_IDLE;
                w_busy_nxt  = 1'b0;
                w_done_nxt  = 1'b1;
            end else begin
                w_state_nxt = ST_RAMP;
                w_busy_nxt  = 1'b1;
            end
        end else if ((r_state == ST_RAMP) && w_tick) begin
            w_duty_nxt = w_step_duty;
            if (w_step_duty == r_target) begin
                w_state_nxt = ST_IDLE;
                w_busy_nxt  = 1'b0;
                w_done_nxt  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_duty     <= DUTY_RESET;
            r_target   <= '0;
            r_step     <= '0;
            r_interval <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_duty     <= w_duty_nxt;
            r_target   <= w_target_nxt;
            r_step     <= w_step_nxt;
            r_interval <= w_interval_nxt;
            r_busy     <= w_busy_nxt;
            r_done     <= w_done_nxt;
        end
    end

    assign duty_cycle = r_duty;
    assign busy       = r_busy;
    assign done       = r_done;

endmodule

// File: tb/tb_pwm_fade_ctrl.sv
// tb/tb_pwm_fade_ctrl.sv - scoreboard bench for pwm_fade_ctrl
module tb_pwm_fade_ctrl;

    localparam logic [15:0] RST_DUTY = 16'h1234;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_valid = 1'b0;
    logic [15:0] cmd_target = '0;
    logic [15:0] cmd_step = '0;
    logic [15:0] cmd_interval = '0;
    logic [15:0] duty_cycle;
    logic        busy;
    logic        done;

    pwm_fade_ctrl #(.DUTY_RESET(RST_DUTY)) dut (
        .clk          (clk),
        .reset        (reset),
        .cmd_valid    (cmd_valid),
        .cmd_target   (cmd_target),
        .cmd_step     (cmd_step),
        .cmd_interval (cmd_interval),
        .duty_cycle   (duty_cycle),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic [15:0] duty;
        bit          done;
    } ev_t;

    ev_t         exp_q[$];
    int          cyc = 0;
    int          total = 0;
    int          bad = 0;
    int          m_base = 0;
    int          busy_from = 0;
    int          busy_end = 0;
    logic [15:0] prev_duty = RST_DUTY;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input bit ok, input string name, input longint act, input longint req);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s at cycle %0d: got %0h want %0h", name, cyc, act, req);
        end
    endtask

    // Monitor: every duty change or done pulse must match the next expected event.
    always @(negedge clk) begin
        if (reset) begin
            prev_duty = RST_DUTY;
            m_base    = int'(RST_DUTY);
        end else begin
            if ((duty_cycle !== prev_duty) || (done !== 1'b0)) begin
                if (exp_q.size() == 0) begin
                    check(1'b0, "unexpected_event", longint'(duty_cycle), longint'(prev_duty));
                end else begin
                    ev_t e;
                    e = exp_q.pop_front();
                    check(cyc == e.cyc, "event_cycle", cyc, e.cyc);
                    check(duty_cycle === e.duty, "event_duty", duty_cycle, e.duty);
                    check(done === e.done, "event_done", done, e.done);
                    m_base = int'(e.duty);
                end
            end
            prev_duty = duty_cycle;
            check(busy === ((cyc >= busy_from) && (cyc < busy_end)), "busy",
                  busy, (cyc >= busy_from) && (cyc < busy_end));
        end
    end

    task automatic align();
        @(negedge clk);
        #1;
    endtask

    // Expected duty after step n is the clamped straight line d +/- n*step at edge k+n*(interval+1).
    task automatic send(input int t, input int s, input int iv);
        int k, d, eff, n, nv;
        ev_t e;
        k   = cyc + 1;
        d   = m_base;
        eff = (s == 0) ? 1 : s;
        exp_q.delete();
        busy_from = k;
        if (t == d) begin
            e.cyc = k; e.duty = 16'(d); e.done = 1'b1;
            exp_q.push_back(e);
            busy_end = k;
        end else begin
            n  = 1;
            nv = d;
            while (nv != t) begin
                if (t > d) begin
                    nv = d + n * eff;
                    if (nv > t) nv = t;
                end else begin
                    nv = d - n * eff;
                    if (nv < t) nv = t;
                end
                e.cyc = k + n * (iv + 1); e.duty = 16'(nv); e.done = (nv == t);
                exp_q.push_back(e);
                n++;
            end
            busy_end = e.cyc;
        end
        cmd_target   = 16'(t);
        cmd_step     = 16'(s);
        cmd_interval = 16'(iv);
        cmd_valid    = 1'b1;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic issue(input int t, input int s, input int iv);
        align();
        send(t, s, iv);
    endtask

    task automatic wait_idle(input int budget);
        for (int j = 0; j < budget; j++) begin
            if ((exp_q.size() == 0) && (cyc >= busy_end)) break;
            align();
        end
        check(exp_q.size() == 0, "fade_complete", exp_q.size(), 0);
    endtask

    // Leaves the bench aligned after a negedge so send() can follow directly.
    task automatic wait_base(input int v, input int budget);
        bit hit;
        hit = 1'b0;
        for (int j = 0; j < budget; j++) begin
            align();
            if (m_base == v) begin
                hit = 1'b1;
                break;
            end
        end
        check(hit, "reach_duty", m_base, v);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t, s, iv, d, diff, mode;
        repeat (3) @(negedge clk);
        check(duty_cycle === RST_DUTY, "reset_duty", duty_cycle, RST_DUTY);
        check(busy === 1'b0, "reset_busy", busy, 0);
        check(done === 1'b0, "reset_done", done, 0);
        #1;
        reset = 1'b0;
        repeat (100) @(negedge clk);
        check(duty_cycle === RST_DUTY, "idle_hold", duty_cycle, RST_DUTY);

        issue(0, 16'h2000, 0);
        wait_idle(50);
        issue(16'h0010, 4, 2);
        wait_idle(100);
        issue(16'h0003, 5, 0);
        wait_idle(50);
        issue(16'hFFF0, 16'hFFFF, 0);
        wait_idle(50);
        issue(16'hFFFF, 16'h0100, 0);
        wait_idle(50);
        check(duty_cycle === 16'hFFFF, "saturate_top", duty_cycle, 16'hFFFF);

        issue(0, 16'hFFFF, 0);
        wait_idle(50);
        issue(16'h0100, 1, 0);
        wait_base(16'h0020, 100);
        send(16'h0010, 1, 0);
        wait_idle(100);
        check(duty_cycle === 16'h0010, "retarget_end", duty_cycle, 16'h0010);

        issue(16'h0018, 1, 0);
        wait_base(16'h0017, 100);
        send(16'h0012, 1, 0);
        wait_idle(100);

        issue(16'h0012, 7, 3);
        wait_idle(20);

        issue(16'h0100, 1, 3);
        repeat (20) @(negedge clk);
        #3;
        reset = 1'b1;
        exp_q.delete();
        busy_from = 0;
        busy_end  = 0;
        #1;
        check(duty_cycle === RST_DUTY, "async_reset_duty", duty_cycle, RST_DUTY);
        check(busy === 1'b0, "async_reset_busy", busy, 0);
        check(done === 1'b0, "async_reset_done", done, 0);
        @(negedge clk);
        #1;
        reset = 1'b0;

        for (int r = 0; r < 40; r++) begin
            align();
            d    = m_base;
            t    = int'($urandom_range(0, 65535));
            iv   = int'($urandom_range(0, 7));
            mode = int'($urandom_range(0, 9));
            if (mode == 0) t = d;
            diff = (t > d) ? (t - d) : (d - t);
            if (mode == 1) s = int'($urandom_range(16'h4000, 16'hFFFF));
            else s = diff / int'($urandom_range(1, 40)) + int'($urandom_range(0, 3));
            if (s > 65535) s = 65535;
            send(t, s, iv);
            if ($urandom_range(0, 1) == 0) wait_idle(5000);
            else repeat ($urandom_range(0, 60)) @(negedge clk);
        end
        wait_idle(5000);
        repeat (5) @(negedge clk);
        check(exp_q.size() == 0, "final_queue_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
